// File: rtl/cdc_pkg.sv
// Shared definitions for the req/ack bundled-data crossing receiver.
// Provides the FSM state encodings and the default acknowledge timeout.
package cdc_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_VALID = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  localparam int unsigned TO_CYCLES_DEF = 1024;

  // Encoding 2'b11 is never entered; it is decoded as IDLE with ack low.
  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_VALID = S_VALID,
    ST_ACK   = S_ACK,
    ST_BAD   = 2'd3
  } state_e;

endpackage

// File: rtl/cdc_hs_rx_sync.sv
// Two-flop synchroniser for K independent single-bit asynchronous signals.
// Ports: clk_i (sampling clock), rst_i (async active-high reset),
//        d_i (asynchronous inputs), q_o (synchronised outputs).
module cdc_hs_rx_sync #(
  parameter int unsigned K = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [K-1:0] d_i,
  output logic [K-1:0] q_o
);

  logic [K-1:0] meta_q;
  logic [K-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cdc_hs_rx.sv
// Destination-side controller of a 4-phase req/ack bundled-data crossing.
// Synchronises req, captures the bundle once, offers it on valid/ready and
// sequences ack back to the source. Flags a source that never drops req.
// Ports: syn_clk/rst_n (clock, async active-low reset); req_async/data_async
//        (source request and bundle); ack (to source, straight from a flop);
//        out_data/out_valid/out_ready (consumer handshake); busy (not IDLE);
//        xfer_cnt (completed transfers, wrapping); err_timeout/err_clr
//        (sticky stuck-request flag and its synchronous clear).
module cdc_hs_rx
  import cdc_pkg::*;
#(
  parameter int unsigned K         = 8,
  parameter int unsigned TO_CYCLES = TO_CYCLES_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             syn_clk,
  input  logic             rst_n,
  input  logic             req_async,
  input  logic [K-1:0]     data_async,
  output logic             ack,
  output logic [K-1:0]     out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             err_timeout,
  input  logic             err_clr
);

  localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [K-1:0]      data_q, data_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              err_q, err_d;
  logic              to_fire;
  logic              req_s;

  // Request synchroniser; its reset is active-high.
  cdc_hs_rx_sync #(
    .K (1)
  ) u_req_sync (
    .clk_i (syn_clk),
    .rst_i (~rst_n),
    .d_i   (req_async),
    .q_o   (req_s)
  );

  // State and datapath registers.
  always_ff @(posedge syn_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    data_d   = data_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    to_cnt_d = '0;          // held at zero outside ACK, cleared on entry
    to_fire  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        if (req_s) begin
          data_d  = data_async;   // the only place the bundle is sampled
          valid_d = 1'b1;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        ack_d = 1'b1;
        if (!req_s) begin
          ack_d   = 1'b0;
          cnt_d   = CNT_W'(cnt_q + 1'b1);
          state_d = ST_IDLE;
        end else if (to_cnt_q < TO_W'(TO_CYCLES)) begin
          to_cnt_d = TO_W'(to_cnt_q + 1'b1);
          to_fire  = (to_cnt_q == TO_W'(TO_CYCLES - 1));
        end else begin
          to_cnt_d = to_cnt_q;    // saturated; no forced recovery
        end
      end
      default: begin
        ack_d   = 1'b0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    // Sticky flag: a timeout firing this cycle beats a clear.
    if (to_fire) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  assign ack         = ack_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign xfer_cnt    = cnt_q;
  assign err_timeout = err_q;
  assign busy        = (state_q == ST_VALID) || (state_q == ST_ACK);

endmodule
